dmem_req_arbiter: RTL and testbench
===================================

// Module: dmem_req_arbiter
// PURPOSE
//  Two-port round-robin arbiter and sequencer in front of the byte-addressed
//  data memory. It shares the single memory port between requester A (CPU
//  load/store stage) and requester B (loader/debug).
//  It validates each request and drives one memory command per transaction.
//  It returns read data or an error to the winner with a one-cycle ack.
// PARAMETERS
//  ADDR_W     32   requester/memory address width
//  DATA_W     32   data width
//  MEM_BYTES  256  memory size in bytes; last legal word address = MEM_BYTES-4
// PORTS
//  clock      in   1       single clock, all state on rising edge
//  reset      in   1       asynchronous, active-high
//  a_req      in   1       A request; held high until a_ack
//  a_we       in   1       1=write, 0=read
//  a_size     in   2       00=word(32b, big-endian), 01=byte, 1x=illegal
//  a_addr     in   ADDR_W  byte address
//  a_wdata    in   DATA_W  write data
//  a_ack      out  1       one-cycle completion pulse
//  a_err      out  1       valid with a_ack; 1=request rejected, memory untouched
//  a_rdata    out  DATA_W  read data, valid with a_ack (0 on write/err)
//  b_*        --   --      same seven signals for requester B
//  mem_addr   out  ADDR_W  to memory Address
//  mem_wdata  out  DATA_W  to memory WriteData
//  mem_tipols out  2       to memory tipols (= latched size)
//  mem_read   out  1       to memory MemRead
//  mem_write  out  1       to memory MemWrite
//  mem_rdata  in   DATA_W  from memory ReadData; registered, valid 1 edge after cmd
//  busy       out  1       high in every state except IDLE
// BEHAVIOUR
//  - All outputs are registered. Reset value of every output is 0. FSM resets to IDLE.
//    The priority pointer resets to A. Reset is honoured mid-transaction:
//    no ack is issued and mem_read/mem_write drop to 0 immediately.
//  - FSM: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE; ERR path IDLE -> RESP.
//  - IDLE: if only one req is high, grant it. If both are high, grant the side
//    opposite the last completed grant (after reset: A first). On grant, latch
//    we/size/addr/wdata and the winner id.
//  - Legality is checked at grant. Any of the following is illegal:
//    size=1x; word with addr[1:0]!=0; word with addr>MEM_BYTES-4;
//    byte with addr>MEM_BYTES-1; byte write (size=01, we=1).
//    Illegal request -> RESP with err=1; no memory command is issued.
//  - ISSUE: drive mem_addr/mem_wdata/mem_tipols for exactly one cycle.
//    Drive mem_read=~we and mem_write=we in that same cycle.
//    Never assert mem_read and mem_write together.
//  - CAPTURE: strobes return to 0. On reads, latch mem_rdata.
//    Byte reads keep bits [7:0] and zero-extend them.
//  - RESP: pulse the winner's ack for 1 cycle with rdata/err.
//    Update the last-grant pointer, then return to IDLE.
//  - Latency, legal access: req sampled at edge N -> ack high during cycle N+3.
//    Latency, illegal access: ack high during cycle N+1.
//  - Throughput: a new grant is possible at the edge after RESP.
//    Back-to-back contention therefore alternates A,B,A,B.
//  - A req dropped before ack does not cancel the transaction; the ack still pulses.
//    A req still high in the cycle after ack counts as a new request.
//  - Address compare is done in ADDR_W bits. Addresses are not wrapped modulo MEM_BYTES.
// TESTING
//  1. Reset, then A word-write 0xDEADBEEF@0x10 and A word-read @0x10
//     -> a_rdata=0xDEADBEEF, a_err=0, ack 3 cycles after grant.
//  2. A and B read together, held for 4 transactions
//     -> grants A,B,A,B; each ack is a single-cycle pulse.
//  3. B byte-read @0x11 after test 1 -> b_rdata=0x000000AD.
//  4. A word-read @0x12, A word @0xFD, A size=10, A byte-write
//     -> each gives a_err=1 one cycle after grant, with no mem_read/mem_write pulse.
//  5. Assert reset during CAPTURE of an A read -> no a_ack, all outputs 0,
//     and the next simultaneous A/B request grants A first.
//  6. Word-read @0xFC (last word) -> a_err=0, data = bytes 0xFC..0xFF.

Source files
------------

// File: rtl/dmem_req_arbiter.sv
// Round-robin arbiter and sequencer sharing one data-memory port between
// requester A (CPU) and requester B (loader/debug). All outputs are registered.
module dmem_req_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_size,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_tipols,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(MEM_BYTES - 1);

  state_t state, state_n;
  logic   prio_b, prio_b_n;
  logic   win_b, win_b_n;
  logic   lat_we, lat_we_n;
  logic [1:0] lat_size, lat_size_n;

  logic              a_ack_n, a_err_n, b_ack_n, b_err_n;
  logic [DATA_W-1:0] a_rdata_n, b_rdata_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic [1:0]        mem_tipols_n;
  logic              mem_read_n, mem_write_n, busy_n;

  logic              sel_b, sel_we, sel_ok;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] cap_data;

  function automatic logic is_legal(input logic we, input logic [1:0] size,
                                    input logic [ADDR_W-1:0] addr);
    logic ok;
    ok = 1'b0;
    if (size == 2'b00)
      ok = (addr[1:0] == 2'b00) && (addr <= LAST_WORD);
    else if (size == 2'b01)
      ok = !we && (addr <= LAST_BYTE);
    return ok;
  endfunction

  // With both requests pending, the side that did not complete last wins.
  always_comb begin
    sel_b     = b_req && (!a_req || prio_b);
    sel_we    = sel_b ? b_we    : a_we;
    sel_size  = sel_b ? b_size  : a_size;
    sel_addr  = sel_b ? b_addr  : a_addr;
    sel_wdata = sel_b ? b_wdata : a_wdata;
    sel_ok    = is_legal(sel_we, sel_size, sel_addr);
  end

  always_comb begin
    if (lat_we)
      cap_data = '0;
    else if (lat_size == 2'b01)
      cap_data = {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
    else
      cap_data = mem_rdata;
  end

  always_comb begin
    state_n      = state;
    prio_b_n     = prio_b;
    win_b_n      = win_b;
    lat_we_n     = lat_we;
    lat_size_n   = lat_size;
    a_ack_n      = 1'b0;
    a_err_n      = 1'b0;
    a_rdata_n    = '0;
    b_ack_n      = 1'b0;
    b_err_n      = 1'b0;
    b_rdata_n    = '0;
    mem_addr_n   = '0;
    mem_wdata_n  = '0;
    mem_tipols_n = 2'b00;
    mem_read_n   = 1'b0;
    mem_write_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (a_req || b_req) begin
          win_b_n    = sel_b;
          lat_we_n   = sel_we;
          lat_size_n = sel_size;
          if (sel_ok) begin
            // Command registers load at the grant edge so they are live in ISSUE.
            state_n      = ISSUE;
            mem_addr_n   = sel_addr;
            mem_wdata_n  = sel_wdata;
            mem_tipols_n = sel_size;
            mem_read_n   = !sel_we;
            mem_write_n  = sel_we;
          end else begin
            state_n = RESP;
            a_ack_n = !sel_b;
            a_err_n = !sel_b;
            b_ack_n = sel_b;
            b_err_n = sel_b;
          end
        end
      end
      ISSUE: state_n = CAPTURE;
      CAPTURE: begin
        state_n   = RESP;
        a_ack_n   = !win_b;
        b_ack_n   = win_b;
        a_rdata_n = win_b ? '0 : cap_data;
        b_rdata_n = win_b ? cap_data : '0;
      end
      RESP: begin
        state_n  = IDLE;
        prio_b_n = !win_b;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prio_b     <= 1'b0;
      win_b      <= 1'b0;
      lat_we     <= 1'b0;
      lat_size   <= 2'b00;
      a_ack      <= 1'b0;
      a_err      <= 1'b0;
      a_rdata    <= '0;
      b_ack      <= 1'b0;
      b_err      <= 1'b0;
      b_rdata    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_tipols <= 2'b00;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      prio_b     <= prio_b_n;
      win_b      <= win_b_n;
      lat_we     <= lat_we_n;
      lat_size   <= lat_size_n;
      a_ack      <= a_ack_n;
      a_err      <= a_err_n;
      a_rdata    <= a_rdata_n;
      b_ack      <= b_ack_n;
      b_err      <= b_err_n;
      b_rdata    <= b_rdata_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      mem_tipols <= mem_tipols_n;
      mem_read   <= mem_read_n;
      mem_write  <= mem_write_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_dmem_req_arbiter.sv
// Directed bench for dmem_req_arbiter with a big-endian byte memory model.
module tb_dmem_req_arbiter;

  logic        clock, reset;
  logic        a_req, a_we, b_req, b_we;
  logic [1:0]  a_size, b_size;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_tipols;
  logic        mem_read, mem_write, busy;

  int pass_cnt = 0;
  int total    = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int both_cnt  = 0;

  logic [7:0] mem [0:255];

  dmem_req_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(256)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_tipols(mem_tipols),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: byte reads return the byte replicated so zero-extension is visible.
  always @(posedge clock) begin
    logic [7:0] ix;
    ix = mem_addr[7:0];
    if (mem_read && mem_write) both_cnt++;
    if (mem_read) begin
      rd_pulses++;
      if (mem_tipols == 2'b01)
        mem_rdata <= {mem[ix], mem[ix], mem[ix], mem[ix]};
      else
        mem_rdata <= {mem[ix], mem[ix+8'd1], mem[ix+8'd2], mem[ix+8'd3]};
    end
    if (mem_write) begin
      wr_pulses++;
      mem[ix]      <= mem_wdata[31:24];
      mem[ix+8'd1] <= mem_wdata[23:16];
      mem[ix+8'd2] <= mem_wdata[15:8];
      mem[ix+8'd3] <= mem_wdata[7:0];
    end
  end

  task automatic run_txn(input logic side, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output int pulses);
    int p0;
    bit seen;
    @(negedge clock);
    p0 = rd_pulses + wr_pulses;
    if (!side) begin
      a_req = 1'b1; a_we = we; a_size = size; a_addr = addr; a_wdata = wdata;
    end else begin
      b_req = 1'b1; b_we = we; b_size = size; b_addr = addr; b_wdata = wdata;
    end
    lat = 0; rdata = 32'h0; err = 1'b0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      lat++;
      if (side ? b_ack : a_ack) begin
        seen  = 1'b1;
        rdata = side ? b_rdata : a_rdata;
        err   = side ? b_err : a_err;
      end
    end
    if (!seen) lat = 99;
    a_req = 1'b0;
    b_req = 1'b0;
    pulses = rd_pulses + wr_pulses - p0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_req = 0; a_we = 0; a_size = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_size = 0; b_addr = 0; b_wdata = 0;
    repeat (2) @(negedge clock);
    total++;
    if ({a_ack, a_err, a_rdata, b_ack, b_err, b_rdata} !== 68'h0)
      $display("FAIL reset_resp a=%b/%b/%h b=%b/%b/%h want all 0",
               a_ack, a_err, a_rdata, b_ack, b_err, b_rdata);
    else pass_cnt++;
    total++;
    if ({mem_addr, mem_wdata, mem_tipols, mem_read, mem_write, busy} !== 69'h0)
      $display("FAIL reset_mem addr=%h wdata=%h tip=%b rd=%b wr=%b busy=%b want all 0",
               mem_addr, mem_wdata, mem_tipols, mem_read, mem_write, busy);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat, pl;
    run_txn(1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, rd, er, lat, pl);
    total++;
    if (er !== 1'b0 || lat != 3 || pl != 1 || rd !== 32'h0)
      $display("FAIL word_write err=%b lat=%0d pulses=%0d rdata=%h want 0/3/1/0", er, lat, pl, rd);
    else pass_cnt++;
    total++;
    if ({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} !== 32'hDEADBEEF)
      $display("FAIL word_write_bytes got %h want deadbeef",
               {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]});
    else pass_cnt++;
    run_txn(1'b0, 1'b0, 2'b00, 32'h10, 32'h0, rd, er, lat, pl);
    total++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 3 || pl != 1)
      $display("FAIL word_read rdata=%h err=%b lat=%0d pulses=%0d want deadbeef/0/3/1", rd, er, lat, pl);
    else pass_cnt++;
  endtask

  task automatic test_byte_read();
    logic [31:0] rd; logic er; int lat, pl;
    run_txn(1'b1, 1'b0, 2'b01, 32'h11, 32'h0, rd, er, lat, pl);
    total++;
    if (rd !== 32'h000000AD || er !== 1'b0 || lat != 3)
      $display("FAIL byte_read_11 rdata=%h err=%b lat=%0d want 000000ad/0/3", rd, er, lat);
    else pass_cnt++;
    run_txn(1'b1, 1'b0, 2'b01, 32'hFF, 32'h0, rd, er, lat, pl);
    total++;
    if (rd !== 32'h00000044 || er !== 1'b0 || lat != 3)
      $display("FAIL byte_read_ff rdata=%h err=%b lat=%0d want 00000044/0/3", rd, er, lat);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq;
    int n, cyc, last_cyc, gap_bad, pulse_bad, data_bad, both_ack;
    logic pa, pb;
    n = 0; cyc = 0; last_cyc = -1; gap_bad = 0; pulse_bad = 0; data_bad = 0; both_ack = 0;
    pa = 0; pb = 0; seq = 4'h0;
    @(negedge clock);
    a_req = 1; a_we = 0; a_size = 2'b00; a_addr = 32'h10;
    b_req = 1; b_we = 0; b_size = 2'b01; b_addr = 32'h13;
    while (n < 4 && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (a_ack && b_ack) both_ack++;
      if ((a_ack && pa) || (b_ack && pb)) pulse_bad++;
      if (a_ack || b_ack) begin
        seq[n] = b_ack;
        if (last_cyc >= 0 && cyc - last_cyc != 4) gap_bad++;
        last_cyc = cyc;
        if (a_ack && a_rdata !== 32'hDEADBEEF) data_bad++;
        if (b_ack && b_rdata !== 32'h000000EF) data_bad++;
        n++;
      end
      pa = a_ack; pb = b_ack;
    end
    a_req = 0; b_req = 0;
    @(negedge clock);
    if (a_ack || b_ack) pulse_bad++;
    total++;
    if (n != 4 || seq !== 4'b1010)
      $display("FAIL rr_order acks=%0d seq(lsb first, 1=B)=%b want 4/1010", n, seq);
    else pass_cnt++;
    total++;
    if (pulse_bad != 0 || both_ack != 0)
      $display("FAIL rr_pulse long_pulses=%0d both=%0d want 0/0", pulse_bad, both_ack);
    else pass_cnt++;
    total++;
    if (gap_bad != 0 || data_bad != 0)
      $display("FAIL rr_timing gap_bad=%0d data_bad=%0d want 0/0", gap_bad, data_bad);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    logic        we_t   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  size_t [6] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01};
    logic [31:0] addr_t [6] = '{32'h12, 32'hFD, 32'h10, 32'h10, 32'h100, 32'h100};
    logic [31:0] rd; logic er; int lat, pl;
    for (int i = 0; i < 6; i++) begin
      run_txn(1'b0, we_t[i], size_t[i], addr_t[i], 32'h12345678, rd, er, lat, pl);
      total++;
      if (er !== 1'b1 || lat != 1 || pl != 0 || rd !== 32'h0)
        $display("FAIL illegal_%0d err=%b lat=%0d pulses=%0d rdata=%h want 1/1/0/0",
                 i, er, lat, pl, rd);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int acks, cyc;
    logic first_a, seen;
    acks = 0; seen = 0; first_a = 0; cyc = 0;
    @(negedge clock);
    a_req = 1; a_we = 0; a_size = 2'b00; a_addr = 32'h10;
    @(posedge clock);
    @(posedge clock);
    #1;
    total++;
    if (busy !== 1'b1 || mem_read !== 1'b0 || a_ack !== 1'b0)
      $display("FAIL capture_state busy=%b rd=%b ack=%b want 1/0/0", busy, mem_read, a_ack);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    total++;
    if ({a_ack, a_err, a_rdata, b_ack, b_err, b_rdata, mem_addr, mem_wdata,
         mem_tipols, mem_read, mem_write, busy} !== 137'h0)
      $display("FAIL reset_mid a_ack=%b busy=%b rd=%b a_rdata=%h mem_addr=%h want all 0",
               a_ack, busy, mem_read, a_rdata, mem_addr);
    else pass_cnt++;
    a_req = 0;
    repeat (3) begin
      @(negedge clock);
      if (a_ack) acks++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (a_ack) acks++;
    end
    total++;
    if (acks != 0)
      $display("FAIL reset_no_ack acks=%0d want 0", acks);
    else pass_cnt++;
    a_req = 1; b_req = 1; b_we = 0; b_size = 2'b00; b_addr = 32'h10;
    while (!seen && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (a_ack || b_ack) begin
        seen = 1; first_a = a_ack && !b_ack;
      end
    end
    a_req = 0;
    cyc = 0;
    while (!b_ack && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    b_req = 0;
    total++;
    if (!seen || !first_a)
      $display("FAIL reset_prio seen=%b first_is_a=%b want 1/1", seen, first_a);
    else pass_cnt++;
    @(negedge clock);
  endtask

  task automatic test_last_word();
    logic [31:0] rd; logic er; int lat, pl;
    run_txn(1'b0, 1'b0, 2'b00, 32'hFC, 32'h0, rd, er, lat, pl);
    total++;
    if (rd !== 32'h11223344 || er !== 1'b0 || lat != 3 || pl != 1)
      $display("FAIL last_word rdata=%h err=%b lat=%0d pulses=%0d want 11223344/0/3/1", rd, er, lat, pl);
    else pass_cnt++;
    total++;
    if (both_cnt != 0)
      $display("FAIL strobe_overlap count=%0d want 0", both_cnt);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hFC] = 8'h11; mem[8'hFD] = 8'h22; mem[8'hFE] = 8'h33; mem[8'hFF] = 8'h44;
    mem_rdata = 32'h0;
    test_reset();
    test_write_read();
    test_byte_read();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_last_word();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
